// File: rtl/cond_brn_predictor.sv
// Conditional-branch resolver with a PC-indexed 2-bit saturating-counter BHT.
// Optional statistics counters are enabled by defining BRN_STATS_EN.
module cond_brn_predictor #(
  parameter int unsigned PC_WIDTH   = 10,
  parameter int unsigned BHT_DEPTH  = 16,
  parameter logic [1:0]  CNT_INIT   = 2'b01,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [PC_WIDTH-1:0] IF_PC,
  output logic                PREDICT_TAKEN,
  input  logic                EX_COND_BRN,
  input  logic                EX_STALL,
  input  logic [1:0]          EX_COND_BRN_TYPE,
  input  logic [PC_WIDTH-1:0] EX_PC,
  input  logic                EX_PRED_TAKEN,
  input  logic                C_FLAG,
  input  logic                Z_FLAG,
  output logic                TAKE_COND_BRN,
  output logic                MISPREDICT
`ifdef BRN_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] BRN_COUNT,
  output logic [STAT_WIDTH-1:0] MISP_COUNT
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [1:0] {
    BRCC = 2'b00,
    BRCS = 2'b01,
    BREQ = 2'b10,
    BRNE = 2'b11
  } brn_type_e;

  logic [1:0]       r_bht [BHT_DEPTH];
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_cond;
  logic             w_train;
  logic [1:0]       w_ex_cnt;
  logic [1:0]       w_cnt_next;
  logic             w_unused_pc;

  assign w_if_idx    = IF_PC[IDX_W-1:0];
  assign w_ex_idx    = EX_PC[IDX_W-1:0];
  assign w_unused_pc = ^{IF_PC, EX_PC};

  // Branch condition from the current flags
  always_comb begin
    w_cond = 1'b0;
    case (brn_type_e'(EX_COND_BRN_TYPE))
      BRCC:    w_cond = ~C_FLAG;
      BRCS:    w_cond =  C_FLAG;
      BREQ:    w_cond =  Z_FLAG;
      BRNE:    w_cond = ~Z_FLAG;
      default: w_cond = 1'b0;
    endcase
  end

  assign TAKE_COND_BRN = EX_COND_BRN & ~RST & w_cond;
  assign MISPREDICT    = EX_COND_BRN & ~RST & (w_cond != EX_PRED_TAKEN);
  assign PREDICT_TAKEN = r_bht[w_if_idx][1];
  assign w_train       = EX_COND_BRN & ~EX_STALL & ~RST;
  assign w_ex_cnt      = r_bht[w_ex_idx];

  // Saturating counter step towards the resolved outcome
  always_comb begin
    w_cnt_next = w_ex_cnt;
    if (w_cond) begin
      if (w_ex_cnt != 2'b11) w_cnt_next = w_ex_cnt + 2'd1;
    end else begin
      if (w_ex_cnt != 2'b00) w_cnt_next = w_ex_cnt - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) r_bht[i] <= CNT_INIT;
    end else if (w_train) begin
      r_bht[w_ex_idx] <= w_cnt_next;
    end
  end

`ifdef BRN_STATS_EN
  logic [STAT_WIDTH-1:0] r_brn_count;
  logic [STAT_WIDTH-1:0] r_misp_count;

  // Saturating statistics, advanced only on training edges
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_brn_count  <= '0;
      r_misp_count <= '0;
    end else if (w_train) begin
      if (r_brn_count != '1) r_brn_count <= r_brn_count + STAT_WIDTH'(1);
      if (MISPREDICT && (r_misp_count != '1)) r_misp_count <= r_misp_count + STAT_WIDTH'(1);
    end
  end

  assign BRN_COUNT  = r_brn_count;
  assign MISP_COUNT = r_misp_count;
`else
  logic [STAT_WIDTH-1:0] w_unused_stat;
  assign w_unused_stat = '0;
`endif

endmodule

// File: tb/tb_cond_brn_predictor.sv
// Directed self-checking bench for cond_brn_predictor; honours BRN_STATS_EN.
module tb_cond_brn_predictor;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] IF_PC;
  logic       PREDICT_TAKEN;
  logic       EX_COND_BRN;
  logic       EX_STALL;
  logic [1:0] EX_COND_BRN_TYPE;
  logic [9:0] EX_PC;
  logic       EX_PRED_TAKEN;
  logic       C_FLAG;
  logic       Z_FLAG;
  logic       TAKE_COND_BRN;
  logic       MISPREDICT;
`ifdef BRN_STATS_EN
  logic [15:0] BRN_COUNT;
  logic [15:0] MISP_COUNT;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_brn  = 0;
  int exp_misp = 0;

  cond_brn_predictor dut (
    .CLK              (CLK),
    .RST              (RST),
    .IF_PC            (IF_PC),
    .PREDICT_TAKEN    (PREDICT_TAKEN),
    .EX_COND_BRN      (EX_COND_BRN),
    .EX_STALL         (EX_STALL),
    .EX_COND_BRN_TYPE (EX_COND_BRN_TYPE),
    .EX_PC            (EX_PC),
    .EX_PRED_TAKEN    (EX_PRED_TAKEN),
    .C_FLAG           (C_FLAG),
    .Z_FLAG           (Z_FLAG),
    .TAKE_COND_BRN    (TAKE_COND_BRN),
    .MISPREDICT       (MISPREDICT)
`ifdef BRN_STATS_EN
    ,
    .BRN_COUNT        (BRN_COUNT),
    .MISP_COUNT       (MISP_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One unstalled branch resolved in EX; checks outcome before the training edge
  task automatic train(input logic [1:0] typ, input logic c, input logic z,
                       input logic [9:0] pc, input logic pred,
                       input logic exp_take, input logic exp_misp);
    EX_COND_BRN = 1'b1; EX_STALL = 1'b0; EX_COND_BRN_TYPE = typ;
    C_FLAG = c; Z_FLAG = z; EX_PC = pc; EX_PRED_TAKEN = pred;
    #1;
    chk("take", 32'(TAKE_COND_BRN), 32'(exp_take));
    chk("misp", 32'(MISPREDICT), 32'(exp_misp));
    exp_brn++;
    if (exp_misp) exp_misp++;
    tick();
    EX_COND_BRN = 1'b0;
    #1;
  endtask

  // Condition table: type, C, Z, expected take (not-taken rows first)
  logic [1:0] tbl_typ  [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
  logic       tbl_c    [8] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
  logic       tbl_z    [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
  logic       tbl_take [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};

  initial begin
    RST = 1'b1; IF_PC = '0; EX_COND_BRN = 1'b0; EX_STALL = 1'b0;
    EX_COND_BRN_TYPE = 2'b00; EX_PC = '0; EX_PRED_TAKEN = 1'b0;
    C_FLAG = 1'b0; Z_FLAG = 1'b0;
    tick();

    // Outputs forced low while in reset, even with a live taken branch
    EX_COND_BRN = 1'b1; EX_COND_BRN_TYPE = 2'b10; Z_FLAG = 1'b1; EX_PC = 10'h003;
    #1;
    chk("rst_take", 32'(TAKE_COND_BRN), 32'd0);
    chk("rst_misp", 32'(MISPREDICT), 32'd0);
    tick();
    RST = 1'b0; EX_COND_BRN = 1'b0;
    #1;
    chk("nobrn_take", 32'(TAKE_COND_BRN), 32'd0);
    chk("nobrn_misp", 32'(MISPREDICT), 32'd0);

    // Fresh table predicts not-taken everywhere
    for (int i = 0; i < 16; i++) begin
      IF_PC = 10'(i);
      #1;
      chk($sformatf("init_pred_%0d", i), 32'(PREDICT_TAKEN), 32'd0);
    end
`ifdef BRN_STATS_EN
    chk("init_brn_cnt", 32'(BRN_COUNT), 32'd0);
    chk("init_misp_cnt", 32'(MISP_COUNT), 32'd0);
`endif

    // Every condition type, stalled so the table must not move
    EX_COND_BRN = 1'b1; EX_STALL = 1'b1; EX_PC = 10'h009; EX_PRED_TAKEN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      EX_COND_BRN_TYPE = tbl_typ[i]; C_FLAG = tbl_c[i]; Z_FLAG = tbl_z[i];
      #1;
      chk($sformatf("cond_take_%0d", i), 32'(TAKE_COND_BRN), 32'(tbl_take[i]));
      chk($sformatf("cond_misp_%0d", i), 32'(MISPREDICT), 32'(tbl_take[i]));
      tick();
    end
    EX_COND_BRN = 1'b0; EX_STALL = 1'b0; IF_PC = 10'h009;
    #1;
    chk("stall_tbl_pred9", 32'(PREDICT_TAKEN), 32'd0);

    // BREQ taken at PC 3 while predicted not-taken: 01 -> 10
    train(2'b10, 1'b0, 1'b1, 10'h003, 1'b0, 1'b1, 1'b1);
    IF_PC = 10'h003;
    #1;
    chk("pc3_pred", 32'(PREDICT_TAKEN), 32'd1);

    // PC 5: four taken BRCS saturate at 11, two not-taken fall to 01
    IF_PC = 10'h005;
    train(2'b01, 1'b1, 1'b0, 10'h005, 1'b0, 1'b1, 1'b1);
    chk("pc5_t1", 32'(PREDICT_TAKEN), 32'd1);
    train(2'b01, 1'b1, 1'b0, 10'h005, 1'b1, 1'b1, 1'b0);
    train(2'b01, 1'b1, 1'b0, 10'h005, 1'b1, 1'b1, 1'b0);
    train(2'b01, 1'b1, 1'b0, 10'h005, 1'b1, 1'b1, 1'b0);
    chk("pc5_t4", 32'(PREDICT_TAKEN), 32'd1);
    train(2'b01, 1'b0, 1'b0, 10'h005, 1'b1, 1'b0, 1'b1);
    chk("pc5_nt1", 32'(PREDICT_TAKEN), 32'd1);
    train(2'b01, 1'b0, 1'b0, 10'h005, 1'b1, 1'b0, 1'b1);
    chk("pc5_nt2", 32'(PREDICT_TAKEN), 32'd0);

    // Read and train PC 7 in one cycle: pre-update value, then new value
    IF_PC = 10'h007; EX_COND_BRN = 1'b1; EX_COND_BRN_TYPE = 2'b11; Z_FLAG = 1'b0; EX_PC = 10'h007;
    #1;
    chk("pc7_same_cycle", 32'(PREDICT_TAKEN), 32'd0);
    train(2'b11, 1'b0, 1'b0, 10'h007, 1'b0, 1'b1, 1'b1);
    chk("pc7_next_cycle", 32'(PREDICT_TAKEN), 32'd1);

    // Stalled not-taken branch at 0x013 aliases entry 3 (currently 10)
    IF_PC = 10'h003;
    EX_COND_BRN = 1'b1; EX_STALL = 1'b1; EX_COND_BRN_TYPE = 2'b11; Z_FLAG = 1'b1;
    EX_PC = 10'h013; EX_PRED_TAKEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_take_%0d", i), 32'(TAKE_COND_BRN), 32'd0);
      chk($sformatf("stall_misp_%0d", i), 32'(MISPREDICT), 32'd1);
      tick();
      chk($sformatf("stall_pred_%0d", i), 32'(PREDICT_TAKEN), 32'd1);
    end
    train(2'b11, 1'b0, 1'b1, 10'h013, 1'b1, 1'b0, 1'b1);
    chk("alias_release", 32'(PREDICT_TAKEN), 32'd0);
    // Exactly one update on release: 01 -> 10 now predicts taken
    train(2'b10, 1'b0, 1'b1, 10'h003, 1'b0, 1'b1, 1'b1);
    chk("alias_single_upd", 32'(PREDICT_TAKEN), 32'd1);

`ifdef BRN_STATS_EN
    chk("brn_cnt", 32'(BRN_COUNT), 32'(exp_brn));
    chk("misp_cnt", 32'(MISP_COUNT), 32'(exp_misp));
`endif

    // Reset coincident with a training request wins and clears all history
    IF_PC = 10'h007; RST = 1'b1;
    EX_COND_BRN = 1'b1; EX_STALL = 1'b0; EX_COND_BRN_TYPE = 2'b11; Z_FLAG = 1'b0;
    EX_PC = 10'h007; EX_PRED_TAKEN = 1'b0;
    #1;
    chk("rst_train_take", 32'(TAKE_COND_BRN), 32'd0);
    tick();
    RST = 1'b0; EX_COND_BRN = 1'b0;
    #1;
    chk("rst_pc7", 32'(PREDICT_TAKEN), 32'd0);
    IF_PC = 10'h003;
    #1;
    chk("rst_pc3", 32'(PREDICT_TAKEN), 32'd0);
`ifdef BRN_STATS_EN
    chk("rst_brn_cnt", 32'(BRN_COUNT), 32'd0);
    chk("rst_misp_cnt", 32'(MISP_COUNT), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
